// File: rtl/jpeg_wbm_arb.sv
// Round-robin arbiter sharing one Wishbone master port between the block-fetch DMA (m0) and write-back DMA (m1).
// Grant registered, held for the whole cyc, followed by a one-cycle release gap; optional watchdog via JPEG_WBARB_TIMEOUT_EN.
module jpeg_wbm_arb #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [3:0]       m0_sel_i,
    input  logic [31:0]      m0_adr_i,
    input  logic [31:0]      m0_dat_i,
    output logic [31:0]      m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [3:0]       m1_sel_i,
    input  logic [31:0]      m1_adr_i,
    input  logic [31:0]      m1_dat_i,
    output logic [31:0]      m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [3:0]       s_sel_o,
    output logic [31:0]      s_adr_o,
    output logic [31:0]      s_dat_o,
    input  logic [31:0]      s_dat_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    output logic [1:0]       gnt_o,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o,
    output logic             timeout_o,
    input  logic             clr_i
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1, REL} state_t;

    state_t state;
    logic   last;
    logic   wd_hit;

`ifdef JPEG_WBARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;

    // Fires on the TIMEOUT-th consecutive granted cycle without a termination.
    assign wd_hit = (gnt_o != 2'b00) && !s_ack_i && !s_err_i && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (gnt_o == 2'b00 || s_ack_i || s_err_i)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
            if (clr_i)
                timeout_o <= 1'b0;
            else if (wd_hit)
                timeout_o <= 1'b1;
        end
    end
`else
    // Watchdog compiled out: the comparison is constant false for any legal TIMEOUT.
    assign wd_hit    = (TIMEOUT < 0);
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            last   <= 1'b1;
            gnt_o  <= 2'b00;
            cnt0_o <= '0;
            cnt1_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last)) begin
                        state  <= GNT0;
                        gnt_o  <= 2'b01;
                        last   <= 1'b0;
                        cnt0_o <= cnt0_o + 1'b1;
                    end else if (m1_cyc_i) begin
                        state  <= GNT1;
                        gnt_o  <= 2'b10;
                        last   <= 1'b1;
                        cnt1_o <= cnt1_o + 1'b1;
                    end
                end
                GNT0: if (!m0_cyc_i || wd_hit) begin
                    state <= REL;
                    gnt_o <= 2'b00;
                end
                GNT1: if (!m1_cyc_i || wd_hit) begin
                    state <= REL;
                    gnt_o <= 2'b00;
                end
                default: begin
                    state <= IDLE;
                    gnt_o <= 2'b00;
                end
            endcase
            // Placed last so a clear beats a same-cycle increment.
            if (clr_i) begin
                cnt0_o <= '0;
                cnt1_o <= '0;
            end
        end
    end

    // s_cyc_o comes only from the registered grant, never from m*_cyc_i.
    always_comb begin
        s_cyc_o = (gnt_o != 2'b00);
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (gnt_o[0]) begin
            s_stb_o = m0_stb_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (gnt_o[1]) begin
            s_stb_o = m1_stb_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = gnt_o[0] & s_ack_i;
    assign m1_ack_o = gnt_o[1] & s_ack_i;
    assign m0_err_o = gnt_o[0] & (s_err_i | wd_hit);
    assign m1_err_o = gnt_o[1] & (s_err_i | wd_hit);
endmodule

// File: tb/tb_jpeg_wbm_arb.sv
// Directed bench for jpeg_wbm_arb: grant latency, round-robin order, release gap, reset, clear and watchdog.
module tb_jpeg_wbm_arb;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [1:0]  gnt_o;
    logic [15:0] cnt0_o, cnt1_o;
    logic        timeout_o, clr_i;

    int n_chk  = 0;
    int n_fail = 0;
    int m0_left;
    logic [1:0] seq [5];

    jpeg_wbm_arb #(.TIMEOUT(16), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_o), .cnt0_o(cnt0_o), .cnt1_o(cnt1_o), .timeout_o(timeout_o), .clr_i(clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 2 time units after the edge.
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        rst_i = 1'b1; clr_i = 1'b0;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'h0; m0_adr_i = '0; m0_dat_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'h0; m1_adr_i = '0; m1_dat_i = '0;
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0;
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_scyc", 32'(s_cyc_o), 32'h0);
        chk("rst_cnt0", 32'(cnt0_o), 32'h0);
        chk("rst_cnt1", 32'(cnt1_o), 32'h0);
        chk("rst_timeout", 32'(timeout_o), 32'h0);
        step();
        rst_i = 1'b0;
        step();

        // Master 0 reads 4 words.
        m0_cyc_i = 1; m0_stb_i = 1; m0_sel_i = 4'hF; m0_adr_i = 32'h0000_0100;
        #1;
        chk("t1_no_comb_cyc", 32'(s_cyc_o), 32'h0);
        step();
        chk("t1_gnt", 32'(gnt_o), 32'h1);
        chk("t1_scyc", 32'(s_cyc_o), 32'h1);
        chk("t1_sadr", s_adr_o, 32'h0000_0100);
        chk("t1_ssel", 32'(s_sel_o), 32'hF);
        for (int i = 0; i < 4; i++) begin
            s_ack_i = 1; s_dat_i = 32'hA000_0000 + 32'(i);
            #1;
            chk("t1_m0ack", 32'(m0_ack_o), 32'h1);
            chk("t1_m1ack", 32'(m1_ack_o), 32'h0);
            chk("t1_m0dat", m0_dat_o, 32'hA000_0000 + 32'(i));
            step();
        end
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        step();
        chk("t1_rel_gnt", 32'(gnt_o), 32'h0);
        chk("t1_rel_scyc", 32'(s_cyc_o), 32'h0);
        chk("t1_rel_sadr", s_adr_o, 32'h0);
        step();
        chk("t1_cnt0", 32'(cnt0_o), 32'h1);

        // Simultaneous request right after reset: master 0 first, then master 1.
        rst_i = 1; #1; rst_i = 0;
        step();
        m0_cyc_i = 1; m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_2000;
        step();
        chk("t2_first", 32'(gnt_o), 32'h1);
        m0_cyc_i = 0;
        step();
        chk("t2_rel", 32'(gnt_o), 32'h0);
        step();
        chk("t2_idle", 32'(gnt_o), 32'h0);
        step();
        chk("t2_second", 32'(gnt_o), 32'h2);
        chk("t2_sadr", s_adr_o, 32'h0000_2000);
        s_err_i = 1; #1;
        chk("t2_m1err", 32'(m1_err_o), 32'h1);
        chk("t2_m0err", 32'(m0_err_o), 32'h0);
        s_err_i = 0;
        chk("t2_cnt0", 32'(cnt0_o), 32'h1);
        chk("t2_cnt1", 32'(cnt1_o), 32'h1);
        m1_cyc_i = 0;
        step();
        step();

        // Master 1 keeps requesting; master 0 runs 3 cycles: grants 0,1,0,1,0.
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10; seq[4] = 2'b01;
        m0_left = 3; m0_cyc_i = 1; m1_cyc_i = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t3_gnt%0d", i), 32'(gnt_o), 32'(seq[i]));
            if (seq[i][0]) begin
                m0_cyc_i = 0;
                m0_left--;
            end else begin
                m1_cyc_i = 0;
            end
            step();
            chk($sformatf("t3_rel%0d", i), 32'(s_cyc_o), 32'h0);
            m0_cyc_i = (m0_left > 0);
            m1_cyc_i = 1;
            step();
        end
        m0_cyc_i = 0; m1_cyc_i = 0;
        step();
        chk("t3_cnt0", 32'(cnt0_o), 32'h4);

        // Asynchronous reset mid-burst.
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0300;
        step();
        s_ack_i = 1; #1;
        chk("t4_pre_ack", 32'(m0_ack_o), 32'h1);
        rst_i = 1; #1;
        chk("t4_scyc", 32'(s_cyc_o), 32'h0);
        chk("t4_sstb", 32'(s_stb_o), 32'h0);
        chk("t4_sadr", s_adr_o, 32'h0);
        chk("t4_ack", 32'(m0_ack_o), 32'h0);
        chk("t4_gnt", 32'(gnt_o), 32'h0);
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        step();
        rst_i = 0;
        chk("t4_cnt0", 32'(cnt0_o), 32'h0);
        chk("t4_cnt1", 32'(cnt1_o), 32'h0);
        m1_cyc_i = 1;
        step();
        chk("t4_gnt1", 32'(gnt_o), 32'h2);
        chk("t4_cnt1_after", 32'(cnt1_o), 32'h1);
        m1_cyc_i = 0;
        step();
        step();

`ifdef JPEG_WBARB_TIMEOUT_EN
        // Stalled slave: watchdog error on the 16th granted cycle, then master 1 gets the bus.
        m0_cyc_i = 1; m1_cyc_i = 1;
        step();
        chk("t5_gnt0", 32'(gnt_o), 32'h1);
        chk("t5_err_early", 32'(m0_err_o), 32'h0);
        for (int i = 0; i < 14; i++) step();
        chk("t5_err_15", 32'(m0_err_o), 32'h0);
        step();
        chk("t5_err_16", 32'(m0_err_o), 32'h1);
        chk("t5_m1err", 32'(m1_err_o), 32'h0);
        chk("t5_to_before", 32'(timeout_o), 32'h0);
        step();
        chk("t5_rel", 32'(gnt_o), 32'h0);
        chk("t5_timeout", 32'(timeout_o), 32'h1);
        chk("t5_err_pulse", 32'(m0_err_o), 32'h0);
        m0_cyc_i = 0;
        step();
        step();
        chk("t5_gnt1", 32'(gnt_o), 32'h2);
        chk("t5_to_sticky", 32'(timeout_o), 32'h1);
        clr_i = 1;
        step();
        clr_i = 0;
        chk("t5_clr", 32'(timeout_o), 32'h0);
        m1_cyc_i = 0;
        step();
        step();
`else
        // No watchdog: a stalled slave keeps the grant.
        m0_cyc_i = 1;
        for (int i = 0; i < 21; i++) step();
        chk("t5_hold", 32'(gnt_o), 32'h1);
        chk("t5_timeout", 32'(timeout_o), 32'h0);
        chk("t5_noerr", 32'(m0_err_o), 32'h0);
        m0_cyc_i = 0;
        step();
        step();
`endif

        // Clear in the same cycle as a new grant.
        m0_cyc_i = 1; clr_i = 1;
        step();
        clr_i = 0;
        chk("t6_gnt", 32'(gnt_o), 32'h1);
        chk("t6_cnt0", 32'(cnt0_o), 32'h0);
        m0_cyc_i = 0;
        step();
        step();
        chk("t6_idle", 32'(gnt_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
